// File: rtl/ms_shift_reg.sv
// ms_shift_reg: bidirectional multi-stage shift register with fill count and tap read.
// Define MS_SHIFT_REG_PARITY_EN to add the registered tail parity output q_par.
module ms_shift_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic [4:0]                   tap_sel,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             q_head,
    output logic [WIDTH-1:0]             tap,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         full
`ifdef MS_SHIFT_REG_PARITY_EN
    ,
    output logic                         q_par
`endif
);
    localparam int FW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [FW-1:0]    fill_q, fill_d;
    logic             full_q, full_d;
    logic             shift;
    assign shift = en && (mode == 2'b01 || mode == 2'b10);
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (en && mode == 2'b01) begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end else if (en && mode == 2'b10) begin
            stage_d[DEPTH-1] = d;
            for (int i = 0; i < DEPTH-1; i++) stage_d[i] = stage_q[i+1];
        end else if (en && mode == 2'b11) begin
            for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
            fill_d = '0;
        end
        if (shift && !full_q) fill_d = fill_q + 1'b1;
        full_d = (fill_d == FW'(DEPTH));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
        end
    end
    // Decoded by compare so out-of-range selects fall through to zero.
    always_comb begin
        tap = '0;
        for (int i = 0; i < DEPTH; i++)
            if (tap_sel == 5'(i)) tap = stage_q[i];
    end
    assign q      = stage_q[DEPTH-1];
    assign q_head = stage_q[0];
    assign fill   = fill_q;
    assign full   = full_q;
`ifdef MS_SHIFT_REG_PARITY_EN
    logic q_par_q;
    always_ff @(posedge clk) begin
        if (rst) q_par_q <= 1'b0;
        else     q_par_q <= ^stage_d[DEPTH-1];
    end
    assign q_par = q_par_q;
`endif
endmodule

// File: tb/tb_ms_shift_reg.sv
// tb_ms_shift_reg: directed checks of ms_shift_reg at WIDTH=8, DEPTH=4.
module tb_ms_shift_reg;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic [4:0] tap_sel = 5'd0;
    logic [7:0] q, q_head, tap;
    logic [2:0] fill;
    logic       full;
    int checks = 0;
    int errors = 0;
`ifdef MS_SHIFT_REG_PARITY_EN
    logic q_par;
`endif

    ms_shift_reg #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .tap_sel(tap_sel),
        .q(q), .q_head(q_head), .tap(tap), .fill(fill), .full(full)
`ifdef MS_SHIFT_REG_PARITY_EN
        , .q_par(q_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] v);
        en = e; mode = m; d = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 2'b01, 8'hFF);
        rst = 1'b0;
        tap_sel = 5'd0;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
        checks++; if (q_head !== 8'h00) begin errors++; $display("FAIL reset_q_head got %h exp 00", q_head); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (tap !== 8'h00) begin errors++; $display("FAIL reset_tap got %h exp 00", tap); end
    endtask

    task automatic test_forward();
        step(1'b1, 2'b01, 8'h11);
        checks++; if (q_head !== 8'h11) begin errors++; $display("FAIL fwd1_head got %h exp 11", q_head); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL fwd1_q got %h exp 00", q); end
        checks++; if (fill !== 3'd1) begin errors++; $display("FAIL fwd1_fill got %0d exp 1", fill); end
        step(1'b1, 2'b01, 8'h22);
        step(1'b1, 2'b01, 8'h33);
        checks++; if (q !== 8'h00 || full !== 1'b0) begin errors++; $display("FAIL fwd3_q_full got %h/%b exp 00/0", q, full); end
        step(1'b1, 2'b01, 8'h44);
        checks++; if (q_head !== 8'h44) begin errors++; $display("FAIL fwd4_head got %h exp 44", q_head); end
        checks++; if (q !== 8'h11) begin errors++; $display("FAIL fwd4_q got %h exp 11", q); end
        checks++; if (fill !== 3'd4) begin errors++; $display("FAIL fwd4_fill got %0d exp 4", fill); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fwd4_full got %b exp 1", full); end
        tap_sel = 5'd1; #1;
        checks++; if (tap !== 8'h33) begin errors++; $display("FAIL fwd4_tap1 got %h exp 33", tap); end
        tap_sel = 5'd2; #1;
        checks++; if (tap !== 8'h22) begin errors++; $display("FAIL fwd4_tap2 got %h exp 22", tap); end
        step(1'b1, 2'b01, 8'h55);
        checks++; if (q !== 8'h22) begin errors++; $display("FAIL fwd5_q got %h exp 22", q); end
        checks++; if (fill !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL fwd5_sat got %0d/%b exp 4/1", fill, full); end
    endtask

    task automatic test_backward();
        step(1'b1, 2'b10, 8'hAA);
        checks++; if (q_head !== 8'h44) begin errors++; $display("FAIL bwd_head got %h exp 44", q_head); end
        checks++; if (q !== 8'hAA) begin errors++; $display("FAIL bwd_q got %h exp AA", q); end
        tap_sel = 5'd1; #1;
        checks++; if (tap !== 8'h33) begin errors++; $display("FAIL bwd_tap1 got %h exp 33", tap); end
        tap_sel = 5'd2; #1;
        checks++; if (tap !== 8'h22) begin errors++; $display("FAIL bwd_tap2 got %h exp 22", tap); end
        checks++; if (fill !== 3'd4) begin errors++; $display("FAIL bwd_fill got %0d exp 4", fill); end
    endtask

    task automatic test_tap_range();
        tap_sel = 5'd3; #1;
        checks++; if (tap !== 8'hAA) begin errors++; $display("FAIL tap3 got %h exp AA", tap); end
        tap_sel = 5'd4; #1;
        checks++; if (tap !== 8'h00) begin errors++; $display("FAIL tap4 got %h exp 00", tap); end
        tap_sel = 5'd31; #1;
        checks++; if (tap !== 8'h00) begin errors++; $display("FAIL tap31 got %h exp 00", tap); end
        tap_sel = 5'd0;
    endtask

    task automatic test_hold_clear();
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 8'h99);
        checks++; if (q !== 8'hAA || q_head !== 8'h44) begin errors++; $display("FAIL hold_en0 got %h/%h exp AA/44", q, q_head); end
        checks++; if (fill !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL hold_en0_fill got %0d/%b exp 4/1", fill, full); end
        step(1'b1, 2'b00, 8'h99);
        checks++; if (q !== 8'hAA || q_head !== 8'h44 || fill !== 3'd4) begin errors++; $display("FAIL hold_mode0 got %h/%h/%0d exp AA/44/4", q, q_head, fill); end
        step(1'b1, 2'b11, 8'h99);
        checks++; if (q !== 8'h00 || q_head !== 8'h00) begin errors++; $display("FAIL clear_data got %h/%h exp 00/00", q, q_head); end
        tap_sel = 5'd2; #1;
        checks++; if (tap !== 8'h00) begin errors++; $display("FAIL clear_tap2 got %h exp 00", tap); end
        checks++; if (fill !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL clear_fill got %0d/%b exp 0/0", fill, full); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 2'b01, 8'h01);
        step(1'b1, 2'b01, 8'h02);
        step(1'b1, 2'b10, 8'h03);
        checks++; if (q_head !== 8'h01) begin errors++; $display("FAIL b2b_head got %h exp 01", q_head); end
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL b2b_q got %h exp 03", q); end
        tap_sel = 5'd1; #1;
        checks++; if (tap !== 8'h00) begin errors++; $display("FAIL b2b_tap1 got %h exp 00", tap); end
        checks++; if (fill !== 3'd3 || full !== 1'b0) begin errors++; $display("FAIL b2b_fill got %0d/%b exp 3/0", fill, full); end
        step(1'b1, 2'b11, 8'h00);
    endtask

    task automatic test_rst_priority();
        step(1'b1, 2'b01, 8'h5A);
        step(1'b1, 2'b01, 8'hA5);
        checks++; if (fill !== 3'd2 || q_head !== 8'hA5) begin errors++; $display("FAIL pre_rst got %0d/%h exp 2/A5", fill, q_head); end
        en = 1'b1; mode = 2'b01; d = 8'hFF; rst = 1'b1;
        #2;
        checks++; if (fill !== 3'd2 || q_head !== 8'hA5) begin errors++; $display("FAIL rst_async got %0d/%h exp 2/A5", fill, q_head); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (q !== 8'h00 || q_head !== 8'h00) begin errors++; $display("FAIL rst_prio_data got %h/%h exp 00/00", q, q_head); end
        checks++; if (fill !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL rst_prio_fill got %0d/%b exp 0/0", fill, full); end
        tap_sel = 5'd1; #1;
        checks++; if (tap !== 8'h00) begin errors++; $display("FAIL rst_prio_tap1 got %h exp 00", tap); end
    endtask

`ifdef MS_SHIFT_REG_PARITY_EN
    task automatic test_parity();
        checks++; if (q_par !== 1'b0) begin errors++; $display("FAIL par_reset got %b exp 0", q_par); end
        step(1'b1, 2'b01, 8'h07);
        step(1'b1, 2'b01, 8'h03);
        step(1'b1, 2'b01, 8'h00);
        step(1'b1, 2'b01, 8'h00);
        checks++; if (q !== 8'h07 || q_par !== 1'b1) begin errors++; $display("FAIL par_07 got %h/%b exp 07/1", q, q_par); end
        step(1'b1, 2'b01, 8'h00);
        checks++; if (q !== 8'h03 || q_par !== 1'b0) begin errors++; $display("FAIL par_03 got %h/%b exp 03/0", q, q_par); end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_backward();
        test_tap_range();
        test_hold_clear();
        test_back_to_back();
        test_rst_priority();
`ifdef MS_SHIFT_REG_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
